// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key count, FSM state type and one-hot helper functions
// for the keypad hit filter.
`default_nettype none

package keypad_pkg;

    localparam int NKEYS = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    function automatic logic [2:0] onehot_to_code(input logic [NKEYS-1:0] v);
        logic [2:0] code;
        code = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (v[i]) begin
                code = code | 3'(i);
            end
        end
        return code;
    endfunction

    function automatic logic is_onehot(input logic [NKEYS-1:0] v);
        return $onehot(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync2_bus.sv
// ============================================================================
// Module   : sync2_bus
// Purpose  : Parameterised-width two-flop synchroniser, asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2_bus #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_hit_filter.sv
// ============================================================================
// Module   : keypad_hit_filter
// Purpose  : Synchronise and debounce an 8-key keypad; emit one one-hot hit
//            strobe per clean single-key press. Define HIT_STICKY_EN to add a
//            sticky last-hit register cleared by hit_ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_hit_filter #(
    parameter int NKEYS           = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [NKEYS-1:0] keypad,
    output logic             hit_valid,
    output logic [NKEYS-1:0] hit_onehot,
    output logic [2:0]       hit_code,
    output logic             key_held,
    output logic             multi_err,
    input  logic             hit_ack,
    output logic [NKEYS-1:0] sticky_hit
);

    import keypad_pkg::*;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NKEYS-1:0] w_ks;

    kp_state_t        r_state;
    kp_state_t        w_state_nxt;
    logic [NKEYS-1:0] r_cand;
    logic [NKEYS-1:0] w_cand_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             r_hit_valid;
    logic             w_hit_valid_nxt;
    logic [NKEYS-1:0] r_hit_onehot;
    logic [NKEYS-1:0] w_hit_onehot_nxt;
    logic [2:0]       r_hit_code;
    logic [2:0]       w_hit_code_nxt;
    logic             r_multi_err;
    logic             w_multi_err_nxt;
    logic             r_key_held;
    logic             w_key_held_nxt;

    sync2_bus #(
        .WIDTH (NKEYS)
    ) u_sync (
        .clk   (clk),
        .RESET (RESET),
        .i_d   (keypad),
        .o_q   (w_ks)
    );

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_hit_valid  <= 1'b0;
            r_hit_onehot <= '0;
            r_hit_code   <= '0;
            r_multi_err  <= 1'b0;
            r_key_held   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hit_valid  <= w_hit_valid_nxt;
            r_hit_onehot <= w_hit_onehot_nxt;
            r_hit_code   <= w_hit_code_nxt;
            r_multi_err  <= w_multi_err_nxt;
            r_key_held   <= w_key_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cand_nxt       = r_cand;
        w_cnt_nxt        = r_cnt;
        w_hit_valid_nxt  = 1'b0;
        w_hit_onehot_nxt = '0;
        w_hit_code_nxt   = '0;
        w_multi_err_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_ks != '0) begin
                    w_state_nxt = PRESS_DB;
                    w_cand_nxt  = w_ks;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_DB: begin
                if (w_ks == '0) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_ks != r_cand) begin
                    w_cand_nxt = w_ks;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = HELD;
                    if (is_onehot(r_cand)) begin
                        w_hit_valid_nxt  = 1'b1;
                        w_hit_onehot_nxt = r_cand;
                        w_hit_code_nxt   = onehot_to_code(r_cand);
                    end else begin
                        w_multi_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                // Extra keys while held are deliberately ignored; only full release counts.
                if (w_ks == '0) begin
                    w_state_nxt = RELEASE_DB;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_DB: begin
                if (w_ks != '0) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_key_held_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_DB);
    end

    assign hit_valid  = r_hit_valid;
    assign hit_onehot = r_hit_onehot;
    assign hit_code   = r_hit_code;
    assign multi_err  = r_multi_err;
    assign key_held   = r_key_held;

`ifdef HIT_STICKY_EN
    logic [NKEYS-1:0] r_sticky_hit;

    // A fresh hit takes priority over a simultaneous acknowledge.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_sticky_hit <= '0;
        end else if (r_hit_valid) begin
            r_sticky_hit <= r_hit_onehot;
        end else if (hit_ack) begin
            r_sticky_hit <= '0;
        end
    end

    assign sticky_hit = r_sticky_hit;
`else
    logic w_unused_ack;
    assign w_unused_ack = hit_ack;
    assign sticky_hit   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_keypad_hit_filter.sv
// Directed bench for keypad_hit_filter with DEBOUNCE_CYCLES=4.
`default_nettype none

module tb_keypad_hit_filter;

    localparam int D = 4;

    logic       clk;
    logic       RESET;
    logic [7:0] keypad;
    logic       hit_valid;
    logic [7:0] hit_onehot;
    logic [2:0] hit_code;
    logic       key_held;
    logic       multi_err;
    logic       hit_ack;
    logic [7:0] sticky_hit;

    keypad_hit_filter #(
        .NKEYS           (8),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clk        (clk),
        .RESET      (RESET),
        .keypad     (keypad),
        .hit_valid  (hit_valid),
        .hit_onehot (hit_onehot),
        .hit_code   (hit_code),
        .key_held   (key_held),
        .multi_err  (multi_err),
        .hit_ack    (hit_ack),
        .sticky_hit (sticky_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    int         nhit, nmulti, nleak, nfall, hit_at, multi_at, fall_at;
    logic [7:0] last_oh;
    logic [2:0] last_code;
    logic       prev_hv, prev_kh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        nhit = 0; nmulti = 0; nleak = 0; nfall = 0;
        hit_at = -1; multi_at = -1; fall_at = -1;
        last_oh = '0; last_code = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (hit_valid) begin
                nhit++;
                hit_at    = cyc;
                last_oh   = hit_onehot;
                last_code = hit_code;
                if (prev_hv) nleak++;
            end else if (hit_onehot != '0 || hit_code != '0) begin
                nleak++;
            end
            if (multi_err) begin
                nmulti++;
                multi_at = cyc;
            end
            if (prev_kh && !key_held) begin
                nfall++;
                fall_at = cyc;
            end
            prev_hv = hit_valid;
            prev_kh = key_held;
        end
    endtask

    task automatic set_key(input logic [7:0] v);
        keypad = v;
        t0     = cyc;
    endtask

    initial begin
        RESET   = 1'b1;
        keypad  = '0;
        hit_ack = 1'b0;
        prev_hv = 1'b0;
        prev_kh = 1'b0;
        clr();
        run(3);
        chk("rst_hit_valid", 32'(hit_valid), 0);
        chk("rst_hit_onehot", 32'(hit_onehot), 0);
        chk("rst_hit_code", 32'(hit_code), 0);
        chk("rst_key_held", 32'(key_held), 0);
        chk("rst_multi_err", 32'(multi_err), 0);
        chk("rst_sticky", 32'(sticky_hit), 0);
        RESET = 1'b0;
        run(3);

        // Clean press of key 2, then release
        clr();
        set_key(8'h04);
        run(20);
        chk("clean_nhit", nhit, 1);
        chk("clean_hit_at", hit_at, t0 + D + 3);
        chk("clean_onehot", 32'(last_oh), 32'h04);
        chk("clean_code", 32'(last_code), 2);
        chk("clean_held", 32'(key_held), 1);
        set_key(8'h00);
        run(12);
        chk("clean_rel_fall_at", fall_at, t0 + D + 3);
        chk("clean_rel_nhit", nhit, 1);
        chk("clean_leak", nleak, 0);
`ifndef HIT_STICKY_EN
        hit_ack = 1'b1;
        run(1);
        hit_ack = 1'b0;
        chk("sticky_tied_zero", 32'(sticky_hit), 0);
`endif

        // Bounce on key 4, then stable
        clr();
        for (int k = 0; k < 3; k++) begin
            keypad = 8'h10; run(2);
            keypad = 8'h00; run(2);
        end
        chk("bounce_no_early_hit", nhit, 0);
        set_key(8'h10);
        run(15);
        chk("bounce_nhit", nhit, 1);
        chk("bounce_hit_at", hit_at, t0 + D + 3);
        chk("bounce_code", 32'(last_code), 4);
        set_key(8'h00);
        run(12);

        // Two keys down: error, no hit; then single key 0
        clr();
        set_key(8'h81);
        run(12);
        chk("multi_nmulti", nmulti, 1);
        chk("multi_at", multi_at, t0 + D + 3);
        chk("multi_nhit", nhit, 0);
        set_key(8'h00);
        run(12);
        set_key(8'h01);
        run(12);
        chk("multi_then_single_nhit", nhit, 1);
        chk("multi_then_single_code", 32'(last_code), 0);
        chk("multi_then_single_oh", 32'(last_oh), 32'h01);
        set_key(8'h00);
        run(12);
        chk("multi_leak", nleak, 0);

        // Hold with a short drop and an extra key: still one press
        clr();
        set_key(8'h02);
        run(20);
        keypad = 8'h00; run(2);
        keypad = 8'h02; run(8);
        keypad = 8'h06; run(10);
        chk("glitch_held", 32'(key_held), 1);
        chk("glitch_no_fall", nfall, 0);
        set_key(8'h00);
        run(12);
        chk("glitch_nhit", nhit, 1);
        chk("glitch_code", 32'(last_code), 1);
        chk("glitch_nmulti", nmulti, 0);

        // Reset mid-debounce, then mid-hold, with key 3 held throughout
        clr();
        set_key(8'h08);
        run(4);
        RESET = 1'b1;
        #1;
        chk("rstdb_hit_valid", 32'(hit_valid), 0);
        chk("rstdb_key_held", 32'(key_held), 0);
        run(1);
        RESET = 1'b0;
        t0 = cyc;
        run(10);
        chk("rstdb_nhit", nhit, 1);
        chk("rstdb_hit_at", hit_at, t0 + D + 3);
        chk("rstdb_code", 32'(last_code), 3);
        chk("rsthold_pre_held", 32'(key_held), 1);
        RESET = 1'b1;
        #1;
        chk("rsthold_key_held", 32'(key_held), 0);
        chk("rsthold_onehot", 32'(hit_onehot), 0);
        run(1);
        prev_kh = 1'b0;
        RESET = 1'b0;
        t0 = cyc;
        run(10);
        chk("rsthold_nhit", nhit, 2);
        chk("rsthold_hit_at", hit_at, t0 + D + 3);
        set_key(8'h00);
        run(12);

`ifdef HIT_STICKY_EN
        clr();
        set_key(8'h20);
        run(10);
        chk("sticky_set", 32'(sticky_hit), 32'h20);
        hit_ack = 1'b1;
        run(1);
        hit_ack = 1'b0;
        chk("sticky_ack", 32'(sticky_hit), 0);
        set_key(8'h00);
        run(12);
        set_key(8'h40);
        run(D + 3);
        chk("sticky_hv_now", 32'(hit_valid), 1);
        hit_ack = 1'b1;
        run(1);
        hit_ack = 1'b0;
        chk("sticky_hit_wins", 32'(sticky_hit), 32'h40);
        set_key(8'h00);
        run(12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
